// File: rtl/sll_64b_iter.sv
// Iterative 64-bit left shifter resolving STEP barrel stages per clock; result after 6/STEP cycles, init ignored while busy.
// Build option SLL_ROTATE_EN adds rot_i to select rotate-left instead of zero-fill.
module sll_64b_iter #(
    parameter int STEP = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_i,
`ifdef SLL_ROTATE_EN
    input  logic        rot_i,
`endif
    input  logic [5:0]  shift_i,
    input  logic [63:0] data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] data_o
);

    if (!(STEP == 1 || STEP == 2 || STEP == 3 || STEP == 6)) begin : g_bad_step
        $error("sll_64b_iter: STEP must be 1, 2, 3 or 6");
    end

    localparam logic [2:0] STEP_W   = 3'(STEP);
    localparam logic [2:0] LAST_CNT = 3'(6 - STEP);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [63:0] work_q, work_d;
    logic [5:0]  sh_q, sh_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [63:0] data_q, data_d;
    logic        rot_en;

    logic [63:0] work_nxt;
    logic [2:0]  idx;
    logic [6:0]  amt;

`ifdef SLL_ROTATE_EN
    logic rot_q, rot_d;
    assign rot_en = rot_q;
`else
    assign rot_en = 1'b0;
`endif

    // Stages cnt..cnt+STEP-1; stage k moves the word by 2^k when sh[k] is set.
    always_comb begin
        work_nxt = work_q;
        idx      = cnt_q;
        amt      = 7'd1;
        for (int k = 0; k < STEP; k++) begin
            idx = cnt_q + 3'(k);
            amt = 7'd1 << idx;
            if (sh_q[idx]) begin
                if (rot_en) begin
                    work_nxt = (work_nxt << amt) | (work_nxt >> (7'd64 - amt));
                end else begin
                    work_nxt = work_nxt << amt;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        data_d  = data_q;
`ifdef SLL_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            IDLE: begin
                if (init_i) begin
                    work_d  = data_i;
                    sh_d    = shift_i;
                    cnt_d   = 3'd0;
                    busy_d  = 1'b1;
                    state_d = BUSY;
`ifdef SLL_ROTATE_EN
                    rot_d   = rot_i;
`endif
                end
            end
            BUSY: begin
                work_d = work_nxt;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 3'd0;
                    data_d  = work_nxt;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + STEP_W;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            work_q  <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
`ifdef SLL_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
`ifdef SLL_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign data_o = data_q;

endmodule

// File: tb/tb_sll_64b_iter.sv
// Directed bench: one shifter instance per legal STEP (1, 2, 3, 6) sharing clock and reset.
module tb_sll_64b_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_v [4];
    logic [5:0]  sh_v   [4];
    logic [63:0] data_v [4];
    logic        busy_w [4];
    logic        done_w [4];
    logic [63:0] dout_w [4];
    logic [63:0] last_v [4];
`ifdef SLL_ROTATE_EN
    logic        rot_v  [4];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sll_64b_iter #(.STEP(1)) u_s1 (
        .clk_i(clk), .rst_i(rst), .init_i(init_v[0]),
`ifdef SLL_ROTATE_EN
        .rot_i(rot_v[0]),
`endif
        .shift_i(sh_v[0]), .data_i(data_v[0]),
        .busy_o(busy_w[0]), .done_o(done_w[0]), .data_o(dout_w[0]));

    sll_64b_iter #(.STEP(2)) u_s2 (
        .clk_i(clk), .rst_i(rst), .init_i(init_v[1]),
`ifdef SLL_ROTATE_EN
        .rot_i(rot_v[1]),
`endif
        .shift_i(sh_v[1]), .data_i(data_v[1]),
        .busy_o(busy_w[1]), .done_o(done_w[1]), .data_o(dout_w[1]));

    sll_64b_iter #(.STEP(3)) u_s3 (
        .clk_i(clk), .rst_i(rst), .init_i(init_v[2]),
`ifdef SLL_ROTATE_EN
        .rot_i(rot_v[2]),
`endif
        .shift_i(sh_v[2]), .data_i(data_v[2]),
        .busy_o(busy_w[2]), .done_o(done_w[2]), .data_o(dout_w[2]));

    sll_64b_iter #(.STEP(6)) u_s6 (
        .clk_i(clk), .rst_i(rst), .init_i(init_v[3]),
`ifdef SLL_ROTATE_EN
        .rot_i(rot_v[3]),
`endif
        .shift_i(sh_v[3]), .data_i(data_v[3]),
        .busy_o(busy_w[3]), .done_o(done_w[3]), .data_o(dout_w[3]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation on instance i and checks busy/done/data each cycle up to
    // the completion edge. Returns #1 after edge T+L with init low.
    task automatic run_op(input int i, input logic [63:0] d, input logic [5:0] s,
                          input int lat, input bit poke, input logic [63:0] exp);
        init_v[i] = 1'b1;
        data_v[i] = d;
        sh_v[i]   = s;
        tick();
        init_v[i] = 1'b0;
        data_v[i] = ~d;
        sh_v[i]   = ~s;
        chk($sformatf("i%0d busy@T", i), 64'(busy_w[i]), 64'd1);
        chk($sformatf("i%0d done@T", i), 64'(done_w[i]), 64'd0);
        chk($sformatf("i%0d hold@T", i), dout_w[i], last_v[i]);
        for (int c = 1; c < lat; c++) begin
            if (poke && c == 1) begin
                init_v[i] = 1'b1;
                data_v[i] = 64'h5555_5555_5555_5555;
                sh_v[i]   = 6'd1;
            end
            tick();
            init_v[i] = 1'b0;
            chk($sformatf("i%0d busy@T+%0d", i, c), 64'(busy_w[i]), 64'd1);
            chk($sformatf("i%0d done@T+%0d", i, c), 64'(done_w[i]), 64'd0);
            chk($sformatf("i%0d hold@T+%0d", i, c), dout_w[i], last_v[i]);
        end
        tick();
        chk($sformatf("i%0d done@T+L", i), 64'(done_w[i]), 64'd1);
        chk($sformatf("i%0d busy@T+L", i), 64'(busy_w[i]), 64'd0);
        chk($sformatf("i%0d data@T+L", i), dout_w[i], exp);
        last_v[i] = exp;
    endtask

    task automatic idle_after(input int i);
        tick();
        chk($sformatf("i%0d done fall", i), 64'(done_w[i]), 64'd0);
        chk($sformatf("i%0d busy idle", i), 64'(busy_w[i]), 64'd0);
        chk($sformatf("i%0d data held", i), dout_w[i], last_v[i]);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            init_v[i] = 1'b0;
            sh_v[i]   = '0;
            data_v[i] = '0;
            last_v[i] = '0;
`ifdef SLL_ROTATE_EN
            rot_v[i]  = 1'b0;
`endif
        end
        #1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("i%0d rst busy", i), 64'(busy_w[i]), 64'd0);
            chk($sformatf("i%0d rst done", i), 64'(done_w[i]), 64'd0);
            chk($sformatf("i%0d rst data", i), dout_w[i], 64'd0);
        end

        // Reset during the third busy cycle aborts the STEP=1 op silently.
        init_v[0] = 1'b1;
        data_v[0] = 64'h1;
        sh_v[0]   = 6'd37;
        tick();
        init_v[0] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", 64'(busy_w[0]), 64'd0);
        chk("abort done", 64'(done_w[0]), 64'd0);
        chk("abort data", dout_w[0], 64'd0);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("abort no done", 64'(done_w[0]), 64'd0);
        end
        chk("abort data kept", dout_w[0], 64'd0);

        // STEP=1 (L=6)
        run_op(0, 64'h1, 6'd37, 6, 1'b0, 64'h0000_0020_0000_0000);
        idle_after(0);
        run_op(0, 64'hF000_0000_0000_000F, 6'd60, 6, 1'b0, 64'hF000_0000_0000_0000);
        idle_after(0);

        // STEP=2 (L=3): shift 63 with an init poke while busy
        run_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 3, 1'b1, 64'h8000_0000_0000_0000);
        idle_after(1);
        idle_after(1);
        run_op(1, 64'h3, 6'd5, 3, 1'b0, 64'h60);
        idle_after(1);

        // STEP=3 (L=2): zero shift then back-to-back init in the done cycle
        run_op(2, 64'hDEAD_BEEF_0123_4567, 6'd0, 2, 1'b0, 64'hDEAD_BEEF_0123_4567);
        run_op(2, 64'h0000_0000_0000_00FF, 6'd42, 2, 1'b0, 64'h0003_FC00_0000_0000);
        idle_after(2);

        // STEP=6 (L=1)
        run_op(3, 64'h0123_4567_89AB_CDEF, 6'd4, 1, 1'b0, 64'h1234_5678_9ABC_DEF0);
        run_op(3, 64'hAAAA_AAAA_AAAA_AAAB, 6'd63, 1, 1'b0, 64'h8000_0000_0000_0000);
        idle_after(3);

`ifdef SLL_ROTATE_EN
        rot_v[0] = 1'b1;
        run_op(0, 64'h8000_0000_0000_0001, 6'd4, 6, 1'b0, 64'h0000_0000_0000_0018);
        idle_after(0);
        rot_v[0] = 1'b0;
        run_op(0, 64'h8000_0000_0000_0001, 6'd4, 6, 1'b0, 64'h0000_0000_0000_0010);
        idle_after(0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
